// File: rtl/mips_lite_pkg.sv
// Shared definitions for the mips_lite instruction-memory path: default
// memory geometry and the boot loader state encoding.
package mips_lite_pkg;

    localparam int IMEM_ADDR_W = 9;
    localparam int IMEM_DATA_W = 32;

    typedef enum logic [2:0] {
        BL_IDLE    = 3'd0,
        BL_CLEAR   = 3'd1,
        BL_LOAD    = 3'd2,
        BL_RELEASE = 3'd3,
        BL_RUN     = 3'd4
    } boot_state_e;

    function automatic logic bl_is_busy(input boot_state_e s);
        return (s == BL_CLEAR) || (s == BL_LOAD) || (s == BL_RELEASE);
    endfunction

endpackage

// File: rtl/imem_boot_loader.sv
// Clears instruction memory, streams a program into it, then releases the
// processor from reset. Every output comes straight from a flop.
module imem_boot_loader
    import mips_lite_pkg::*;
#(
    parameter int ADDR_W     = IMEM_ADDR_W,
    parameter int DATA_W     = IMEM_DATA_W,
    parameter int CLR_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   word_count,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              inst_mem_rstn,
    output logic              inst_mem_wr_en,
    output logic [ADDR_W-1:0] inst_mem_wr_addr,
    output logic [DATA_W-1:0] inst_mem_wr_data,
    output logic              cpu_rstn,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W:0] MAX_CNT  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [3:0]      CLR_LAST = 4'(CLR_CYCLES - 1);

    boot_state_e       state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [3:0]        clr_q, clr_d;
    logic              rel_q, rel_d;
    logic              s_ready_q, s_ready_d;
    logic              mem_rstn_q, mem_rstn_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              cpu_rstn_q, cpu_rstn_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        clr_d     = clr_q;
        rel_d     = rel_q;
        error_d   = error_q;
        done_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            BL_IDLE, BL_RUN: begin
                if (start) begin
                    cnt_d   = (word_count > MAX_CNT) ? MAX_CNT : word_count;
                    idx_d   = '0;
                    clr_d   = CLR_LAST;
                    error_d = 1'b0;
                    state_d = BL_CLEAR;
                end
            end
            BL_CLEAR: begin
                if (abort) begin
                    error_d = 1'b1;
                    state_d = BL_IDLE;
                end else if (clr_q == 4'd0) begin
                    rel_d   = 1'b1;
                    state_d = (cnt_q != '0) ? BL_LOAD : BL_RELEASE;
                end else begin
                    clr_d = clr_q - 4'd1;
                end
            end
            BL_LOAD: begin
                // abort wins over a same-cycle handshake: that word is dropped
                if (abort) begin
                    error_d = 1'b1;
                    state_d = BL_IDLE;
                end else if (s_valid && s_ready_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q[ADDR_W-1:0];
                    wr_data_d = s_data;
                    idx_d     = idx_q + 1'b1;
                    if (idx_d == cnt_q) begin
                        rel_d   = 1'b1;
                        state_d = BL_RELEASE;
                    end
                end
            end
            BL_RELEASE: begin
                if (abort) begin
                    error_d = 1'b1;
                    state_d = BL_IDLE;
                end else if (!rel_q) begin
                    done_d  = 1'b1;
                    state_d = BL_RUN;
                end else begin
                    rel_d = 1'b0;
                end
            end
            default: state_d = BL_IDLE;
        endcase

        // Status outputs follow the state being entered so they line up with it.
        s_ready_d  = (state_d == BL_LOAD);
        busy_d     = bl_is_busy(state_d);
        cpu_rstn_d = (state_d == BL_RUN);
        mem_rstn_d = (state_d != BL_CLEAR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BL_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            clr_q      <= '0;
            rel_q      <= 1'b0;
            s_ready_q  <= 1'b0;
            mem_rstn_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_rstn_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            clr_q      <= clr_d;
            rel_q      <= rel_d;
            s_ready_q  <= s_ready_d;
            mem_rstn_q <= mem_rstn_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_rstn_q <= cpu_rstn_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign s_ready          = s_ready_q;
    assign inst_mem_rstn    = mem_rstn_q;
    assign inst_mem_wr_en   = wr_en_q;
    assign inst_mem_wr_addr = wr_addr_q;
    assign inst_mem_wr_data = wr_data_q;
    assign cpu_rstn         = cpu_rstn_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: load, gapped stream, empty and
// oversized programs, abort and mid-load reset.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [9:0]  word_count = '0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready;
    logic        inst_mem_rstn;
    logic        inst_mem_wr_en;
    logic [8:0]  inst_mem_wr_addr;
    logic [31:0] inst_mem_wr_data;
    logic        cpu_rstn;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    imem_boot_loader #(.ADDR_W(9), .DATA_W(32), .CLR_CYCLES(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .word_count       (word_count),
        .s_valid          (s_valid),
        .s_data           (s_data),
        .s_ready          (s_ready),
        .inst_mem_rstn    (inst_mem_rstn),
        .inst_mem_wr_en   (inst_mem_wr_en),
        .inst_mem_wr_addr (inst_mem_wr_addr),
        .inst_mem_wr_data (inst_mem_wr_data),
        .cpu_rstn         (cpu_rstn),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    always #5 clk = ~clk;

    // Passive log of memory writes, clear cycles and done pulses.
    int          cyc = 0;
    logic [8:0]  wa_log[$];
    logic [31:0] wd_log[$];
    int          wc_log[$];
    int          clr_cycles = 0;
    int          last_clr_cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (inst_mem_wr_en) begin
                wa_log.push_back(inst_mem_wr_addr);
                wd_log.push_back(inst_mem_wr_data);
                wc_log.push_back(cyc);
            end
            if (!inst_mem_rstn) begin
                clr_cycles++;
                last_clr_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %-22s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_cpu_rstn"}, 64'(cpu_rstn), 0);
        check({p, "_mem_rstn"}, 64'(inst_mem_rstn), 0);
        check({p, "_s_ready"}, 64'(s_ready), 0);
        check({p, "_wr_en"}, 64'(inst_mem_wr_en), 0);
        check({p, "_wr_addr"}, 64'(inst_mem_wr_addr), 0);
        check({p, "_wr_data"}, 64'(inst_mem_wr_data), 0);
        check({p, "_busy"}, 64'(busy), 0);
        check({p, "_done"}, 64'(done), 0);
        check({p, "_error"}, 64'(error), 0);
    endtask

    task automatic pulse_start(input int count);
        word_count = 10'(count);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Streams base+k for accepted word k; stops on done or when busy drops.
    task automatic feed(input bit toggle, input logic [31:0] base, input int abort_at,
                        input int max_hs, output int hs);
        int  k = 0;
        int  phase = 0;
        bit  hs_now;
        bit  finished = 0;
        for (int c = 0; c < 2000 && !finished; c++) begin
            s_data  = base + 32'(k);
            s_valid = toggle ? (phase % 2 == 0) : 1'b1;
            abort   = (abort_at >= 0) && (k == abort_at) && s_valid && s_ready;
            hs_now  = s_valid && s_ready && !abort;
            if (s_ready) phase++;
            tick();
            abort = 1'b0;
            if (hs_now) k++;
            if (done || !busy || (max_hs > 0 && k >= max_hs)) finished = 1;
        end
        s_valid = 1'b0;
        check("feed_finished", 64'(finished), 1);
        hs = k;
    endtask

    int wb, cb, db, hs, bad;

    initial begin
        // Reset state
        #12;
        check_reset_vals("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        check("idle_mem_rstn", 64'(inst_mem_rstn), 1);
        check("idle_cpu_rstn", 64'(cpu_rstn), 0);

        // Four words back to back
        wb = wa_log.size(); cb = clr_cycles; db = done_cnt;
        pulse_start(4);
        check("s1_busy", 64'(busy), 1);
        feed(0, 32'h2008_0001, -1, 0, hs);
        check("s1_done", 64'(done), 1);
        check("s1_cpu_rstn", 64'(cpu_rstn), 1);
        check("s1_busy_end", 64'(busy), 0);
        tick();
        check("s1_done_pulse", 64'(done), 0);
        check("s1_clr_len", 64'(clr_cycles - cb), 4);
        check("s1_writes", 64'(wa_log.size() - wb), 4);
        bad = 0;
        for (int i = 0; i < 4 && wb + i < wa_log.size(); i++) begin
            if (wa_log[wb+i] != 9'(i)) bad++;
            if (wd_log[wb+i] != 32'h2008_0001 + 32'(i)) bad++;
            if (i > 0 && wc_log[wb+i] != wc_log[wb+i-1] + 1) bad++;
        end
        check("s1_addr_data_bad", 64'(bad), 0);
        check("s1_release_len", 64'(done_cyc - wc_log[wa_log.size()-1]), 2);
        check("s1_done_cnt", 64'(done_cnt - db), 1);

        // Three words with gaps, restarted from RUN
        wb = wa_log.size();
        pulse_start(3);
        check("s2_cpu_rstn_drop", 64'(cpu_rstn), 0);
        feed(1, 32'hA000_0000, -1, 0, hs);
        tick();
        check("s2_writes", 64'(wa_log.size() - wb), 3);
        bad = 0;
        for (int i = 0; i < 3 && wb + i < wa_log.size(); i++) begin
            if (wa_log[wb+i] != 9'(i)) bad++;
            if (wd_log[wb+i] != 32'hA000_0000 + 32'(i)) bad++;
            if (i > 0 && wc_log[wb+i] != wc_log[wb+i-1] + 2) bad++;
        end
        check("s2_addr_gap_bad", 64'(bad), 0);

        // Empty program
        wb = wa_log.size(); cb = clr_cycles; db = done_cnt;
        pulse_start(0);
        feed(0, 32'h0, -1, 0, hs);
        check("s3_cpu_rstn", 64'(cpu_rstn), 1);
        tick();
        check("s3_clr_len", 64'(clr_cycles - cb), 4);
        check("s3_writes", 64'(wa_log.size() - wb), 0);
        check("s3_release_len", 64'(done_cyc - last_clr_cyc), 3);
        check("s3_done_cnt", 64'(done_cnt - db), 1);

        // Oversized count clamps to the full memory
        wb = wa_log.size();
        pulse_start(600);
        feed(0, 32'h1000_0000, -1, 0, hs);
        tick();
        check("s4_writes", 64'(wa_log.size() - wb), 512);
        check("s4_last_addr", 64'(wa_log[wa_log.size()-1]), 511);
        bad = 0;
        for (int i = 0; wb + i < wa_log.size(); i++)
            if (wa_log[wb+i] != 9'(i) || wd_log[wb+i] != 32'h1000_0000 + 32'(i)) bad++;
        check("s4_seq_bad", 64'(bad), 0);

        // Abort on the third handshake
        wb = wa_log.size();
        pulse_start(8);
        feed(0, 32'h3000_0000, 2, 0, hs);
        check("s5_busy", 64'(busy), 0);
        check("s5_error", 64'(error), 1);
        check("s5_cpu_rstn", 64'(cpu_rstn), 0);
        check("s5_s_ready", 64'(s_ready), 0);
        tick(); tick();
        check("s5_writes", 64'(wa_log.size() - wb), 2);
        pulse_start(1);
        check("s5_error_cleared", 64'(error), 0);
        feed(0, 32'h3100_0000, -1, 0, hs);
        check("s5_reload_done", 64'(done), 1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("run_abort_cpu_rstn", 64'(cpu_rstn), 1);
        check("run_abort_error", 64'(error), 0);

        // Reset in the middle of a load
        pulse_start(8);
        feed(0, 32'h4000_0000, -1, 3, hs);
        check("s6_hs_before_rst", 64'(hs), 3);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        tick();
        rst = 1'b0;
        tick();
        check("s6_mem_rstn", 64'(inst_mem_rstn), 1);
        pulse_start(2);
        feed(0, 32'h5000_0000, -1, 0, hs);
        tick();
        check("s6_run_cpu_rstn", 64'(cpu_rstn), 1);
        wb = wa_log.size();
        pulse_start(3);
        check("s6_cpu_rstn_drop", 64'(cpu_rstn), 0);
        feed(0, 32'h6000_0000, -1, 0, hs);
        tick();
        check("s6_writes", 64'(wa_log.size() - wb), 3);
        bad = 0;
        for (int i = 0; i < 3 && wb + i < wa_log.size(); i++)
            if (wa_log[wb+i] != 9'(i) || wd_log[wb+i] != 32'h6000_0000 + 32'(i)) bad++;
        check("s6_reload_bad", 64'(bad), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
